// File: rtl/state_seq_pkg.sv
// Shared state encodings and C/Y circuit equations for the state sequencer.
// The equations are consumed by seq_ref_model when SEQ_MODEL_CHECK_EN is defined.
package state_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CLR  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CLR  = ST_CLR,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Next {Q1,Q0} of the C/Y circuit for input c
    function automatic logic [1:0] f_next_q(input logic [1:0] q, input logic c);
        logic q1_n;
        logic q0_n;
        q1_n = (q[0] & ~c) | (q[1] & c);
        q0_n = (~q[1] & c) | (q[0] & ~c);
        return {q1_n, q0_n};
    endfunction

    function automatic logic f_y(input logic [1:0] q, input logic c);
        return (q[1] & c) | (q[1] & q[0] & ~c);
    endfunction

endpackage

// File: rtl/seq_ref_model.sv
// Golden Q1/Q0 register pair of the C/Y circuit, cleared in CLR and stepped in RUN.
// Instantiated by state_seq_ctrl only when SEQ_MODEL_CHECK_EN is defined.
module seq_ref_model
    import state_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic step,
    input  logic c,
    output logic ym
);

    logic [1:0] q_q;
    logic [1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 2'b00;
        end else if (step) begin
            q_d = f_next_q(q_q, c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 2'b00;
        end else begin
            q_q <= q_d;
        end
    end

    assign ym = f_y(q_q, c);

endmodule

// File: rtl/state_seq_ctrl.sv
// Sequencer that clears the C/Y state circuit, plays a C pattern LSB first and records Y.
// Optional SEQ_MODEL_CHECK_EN adds a golden model that flags any Y disagreement.
module state_seq_ctrl
    import state_seq_pkg::*;
#(
    parameter int PAT_W = 16,
    parameter int CNT_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pat,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             c_out,
    output logic             circ_rst_n,
    input  logic             y_in,
    output logic [PAT_W-1:0] y_cap,
    output logic [CNT_W-1:0] y_cnt,
    output logic             mismatch
);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [PAT_W-1:0] y_cap_q, y_cap_d;
    logic [CNT_W-1:0] y_cnt_q, y_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             c_out_q, c_out_d;

    // pat_q shifts right each RUN step so the current C bit is always pat_q[0]
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        y_cap_d = y_cap_q;
        y_cnt_d = y_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    y_cap_d = '0;
                    y_cnt_d = '0;
                    if (len != '0) begin
                        pat_d   = pat;
                        len_d   = (len > CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : len;
                        state_d = CLR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CLR: begin
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                y_cap_d = y_cap_q | (PAT_W'(y_in) << idx_q);
                y_cnt_d = y_cnt_q + CNT_W'(y_in);
                pat_d   = pat_q >> 1;
                if (idx_q == len_q - CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == CLR) || (state_d == RUN);
        done_d  = (state_d == DONE);
        c_out_d = (state_d == RUN) ? pat_d[0] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            y_cap_q <= '0;
            y_cnt_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            y_cap_q <= y_cap_d;
            y_cnt_q <= y_cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            c_out_q <= c_out_d;
        end
    end

`ifdef SEQ_MODEL_CHECK_EN
    logic ym;
    logic mismatch_q, mismatch_d;

    seq_ref_model u_ref_model (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == CLR),
        .step  (state_q == RUN),
        .c     (c_out_q),
        .ym    (ym)
    );

    // Sticky until the next accepted start
    always_comb begin
        mismatch_d = mismatch_q;
        if ((state_q == IDLE) && start) begin
            mismatch_d = 1'b0;
        end else if ((state_q == RUN) && (y_in != ym)) begin
            mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign c_out      = c_out_q;
    assign circ_rst_n = rst_n & ~(state_q == CLR);
    assign y_cap      = y_cap_q;
    assign y_cnt      = y_cnt_q;

endmodule

// File: tb/tb_state_seq_ctrl.sv
// Scoreboard bench for state_seq_ctrl driving a behavioural C/Y circuit.
// Define SEQ_MODEL_CHECK_EN to also exercise the mismatch flag.
module tb_state_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pat = '0;
    logic [4:0]  len = '0;
    logic        busy, done, c_out, circ_rst_n, y_in, mismatch;
    logic [15:0] y_cap;
    logic [4:0]  y_cnt;
    logic [1:0]  circ_q;
    logic        y_force = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] cap;
        logic [4:0]  cnt;
        logic        mis;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    state_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pat        (pat),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .c_out      (c_out),
        .circ_rst_n (circ_rst_n),
        .y_in       (y_in),
        .y_cap      (y_cap),
        .y_cnt      (y_cnt),
        .mismatch   (mismatch)
    );

    function automatic logic [1:0] circNext(input logic [1:0] q, input logic c);
        return {(q[0] & ~c) | (q[1] & c), (~q[1] & c) | (q[0] & ~c)};
    endfunction

    function automatic logic circY(input logic [1:0] q, input logic c);
        return (q[1] & c) | (q[1] & q[0] & ~c);
    endfunction

    // The attached state circuit, reset through the sequencer
    always_ff @(posedge clk or negedge circ_rst_n) begin
        if (!circ_rst_n) circ_q <= 2'b00;
        else             circ_q <= circNext(circ_q, c_out);
    end

    assign y_in = y_force | circY(circ_q, c_out);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Push expected results, issue start, then follow the run until done and pop
    task automatic applyStimulus(input string tag, input logic [15:0] p, input logic [4:0] l,
                                 input int exp_cyc, input int inj_run, input bit inj_done,
                                 input bit frc0);
        exp_t e;
        logic [1:0] q;
        logic c, y;
        int eff, cyc, step, clr_n;
        bit got_done;

        eff = (l > 5'd16) ? 16 : int'(l);
        q = 2'b00;
        e.cap = '0;
        e.cnt = '0;
        for (int k = 0; k < eff; k++) begin
            c = p[k];
            y = circY(q, c) | (frc0 && k == 0);
            e.cap[k] = y;
            e.cnt = e.cnt + 5'(y);
            q = circNext(q, c);
        end
`ifdef SEQ_MODEL_CHECK_EN
        e.mis = frc0;
`else
        e.mis = 1'b0;
`endif
        e.done_cyc = exp_cyc;
        sb.push_back(e);

        @(negedge clk);
        pat = p;
        len = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        step = 0;
        clr_n = 0;
        got_done = 1'b0;
        while (cyc < 60) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            y_force = 1'b0;
            if (!circ_rst_n) begin
                clr_n++;
            end else if (busy && step < 16) begin
                checkOutput({tag, ".c_out"}, 32'(c_out), 32'(p[step]));
                y_force = frc0 && (step == 0);
                step++;
            end
            if (cyc == inj_run) begin
                start = 1'b1;
                pat = 16'hA5A5;
                len = 5'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        y_force = 1'b0;
        start = 1'b0;

        checkOutput({tag, ".done_seen"}, 32'(got_done), 32'd1);
        e = sb.pop_front();
        checkOutput({tag, ".done_cyc"}, cyc, e.done_cyc);
        checkOutput({tag, ".clr_cycles"}, clr_n, (eff != 0) ? 1 : 0);
        checkOutput({tag, ".steps"}, step, eff);
        checkOutput({tag, ".y_cap"}, 32'(y_cap), 32'(e.cap));
        checkOutput({tag, ".y_cnt"}, 32'(y_cnt), 32'(e.cnt));
        checkOutput({tag, ".mismatch"}, 32'(mismatch), 32'(e.mis));
        checkOutput({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        checkOutput({tag, ".c_out_at_done"}, 32'(c_out), 32'd0);
        if (inj_done) begin
            start = 1'b1;
            pat = 16'h5A5A;
            len = 5'd3;
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".c_out"}, 32'(c_out), 32'd0);
        checkOutput({tag, ".circ_rst_n"}, 32'(circ_rst_n), 32'd0);
        checkOutput({tag, ".y_cap"}, 32'(y_cap), 32'd0);
        checkOutput({tag, ".y_cnt"}, 32'(y_cnt), 32'd0);
        checkOutput({tag, ".mismatch"}, 32'(mismatch), 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        checkReset("t1");
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus("t2", 16'h0033, 5'd7, 9, 0, 1'b0, 1'b0);
        checkOutput("t2.y_cap_const", 32'(y_cap), 32'h0038);
        checkOutput("t2.y_cnt_const", 32'(y_cnt), 32'd3);

        applyStimulus("t3", 16'hFFFF, 5'd0, 1, 0, 1'b0, 1'b0);
        applyStimulus("t4a", 16'hFFFF, 5'd16, 18, 0, 1'b0, 1'b0);
        applyStimulus("t4b", 16'hFFFF, 5'd20, 18, 0, 1'b0, 1'b0);
        applyStimulus("rnd", 16'($urandom), 5'd10, 12, 0, 1'b0, 1'b0);

        // Starts in RUN and on the done cycle are ignored; the next one is taken
        applyStimulus("t5a", 16'h0033, 5'd7, 9, 4, 1'b1, 1'b0);
        applyStimulus("t5b", 16'h000F, 5'd4, 6, 0, 1'b0, 1'b0);

        // Reset in the middle of RUN step 3
        @(negedge clk);
        pat = 16'h0009;
        len = 5'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t6.busy_pre", 32'(busy), 32'd1);
        checkOutput("t6.c_out_pre", 32'(c_out), 32'd1);
        checkOutput("t6.y_cnt_pre", 32'(y_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        checkReset("t6");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef SEQ_MODEL_CHECK_EN
        applyStimulus("t7", 16'h0033, 5'd7, 9, 0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("t7.sticky", 32'(mismatch), 32'd1);
        applyStimulus("t7clr", 16'h0033, 5'd7, 9, 0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
